// File: rtl/fwft_fifo_pkt_reader.sv
// Packet reader for the read side of a first-word-fall-through FIFO.
// It pops a header word that carries the payload beat count, then pops that
// many payload words. The payload goes out on a valid/ready stream with an
// end-of-packet marker. A two-entry skid buffer sits between the FIFO pop and
// the stream output, so i_tready never feeds the pop decision.
module fwft_fifo_pkt_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_fifo_rd_en,
    output logic                  o_tvalid,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tlast,
    input  logic                  i_tready,
    output logic [CNT_WIDTH-1:0]  o_pkt_cnt,
    output logic                  o_len_err,
    output logic                  o_busy
);

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;

    logic [LEN_WIDTH-1:0]  hdr_len;
    logic                  push;
    logic                  pop;
    logic                  push_last;

    assign hdr_len = i_fifo_rd_data[LEN_WIDTH-1:0];

    // Header pops need no buffer room; payload pops need a free skid slot.
    assign o_fifo_rd_en = rst_n && !i_clr && !i_fifo_empty &&
                          ((state == IDLE) || (buf_count != 2'd2));

    assign push      = o_fifo_rd_en && (state == PAYLOAD);
    assign pop       = o_tvalid && i_tready;
    assign push_last = (remaining == LEN_WIDTH'(1));

    assign o_tvalid = (buf_count != 2'd0);
    assign o_busy   = (state != IDLE) || (buf_count != 2'd0);

    // Header/payload sequencing: load the beat count, then count payload pops down.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            state     <= IDLE;
            remaining <= '0;
            o_len_err <= 1'b0;
        end else begin
            o_len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (o_fifo_rd_en) begin
                        if (hdr_len == '0) begin
                            o_len_err <= 1'b1;
                        end else begin
                            remaining <= hdr_len;
                            state     <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (o_fifo_rd_en) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (push_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid buffer: the output register is the head entry and skid_* is the
    // second entry; a pop from the full buffer promotes the second entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_count <= 2'd0;
            o_tdata   <= '0;
            o_tlast   <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else if (i_clr) begin
            buf_count <= 2'd0;
            o_tlast   <= 1'b0;
        end else begin
            case (buf_count)
                2'd0: begin
                    if (push) begin
                        o_tdata   <= i_fifo_rd_data;
                        o_tlast   <= push_last;
                        buf_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        o_tdata <= i_fifo_rd_data;
                        o_tlast <= push_last;
                    end else if (push) begin
                        skid_data <= i_fifo_rd_data;
                        skid_last <= push_last;
                        buf_count <= 2'd2;
                    end else if (pop) begin
                        o_tlast   <= 1'b0;
                        buf_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        o_tdata   <= skid_data;
                        o_tlast   <= skid_last;
                        buf_count <= 2'd1;
                    end
                end
                default: buf_count <= 2'd0;
            endcase
        end
    end

    // Completed-packet counter; survives a flush, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_pkt_cnt <= '0;
        end else if (!i_clr && pop && o_tlast) begin
            o_pkt_cnt <= o_pkt_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fwft_fifo_pkt_reader.sv
// Bench for fwft_fifo_pkt_reader. A small array model stands in for the
// FWFT FIFO. Cycle tables cover the basic packet and the back-pressure
// stall. Hand-written sequences cover back-to-back packets, zero-length
// headers, flush, a trickling upstream and reset in the middle of a packet.
module tb_fwft_fifo_pkt_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_clr;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_rd_data;
    logic        o_fifo_rd_en;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        i_tready;
    logic [15:0] o_pkt_cnt;
    logic        o_len_err;
    logic        o_busy;

    fwft_fifo_pkt_reader #(
        .DATA_WIDTH(32),
        .LEN_WIDTH (16),
        .CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (i_clr),
        .i_fifo_empty  (i_fifo_empty),
        .i_fifo_rd_data(i_fifo_rd_data),
        .o_fifo_rd_en  (o_fifo_rd_en),
        .o_tvalid      (o_tvalid),
        .o_tdata       (o_tdata),
        .o_tlast       (o_tlast),
        .i_tready      (i_tready),
        .o_pkt_cnt     (o_pkt_cnt),
        .o_len_err     (o_len_err),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: the head word is visible whenever it is non-empty.
    logic [31:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign i_fifo_empty   = (rd_ptr == wr_ptr);
    assign i_fifo_rd_data = fifo_mem[rd_ptr % 64];

    // Pop on rd_en; reset and clr flush the FIFO as the shared clear would.
    always @(posedge clk) begin
        if (!rst_n || i_clr)
            rd_ptr <= wr_ptr;
        else if (o_fifo_rd_en && !i_fifo_empty)
            rd_ptr <= rd_ptr + 1;
    end

    // Stream monitor: record every accepted beat and count pulses and illegal pops.
    logic [31:0] beat_data [0:255];
    bit          beat_last [0:255];
    int          beat_cyc  [0:255];
    int          beat_n    = 0;
    int          cyc       = 0;
    int          len_err_n = 0;
    int          bad_pop_n = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && o_tvalid && i_tready && beat_n < 256) begin
            beat_data[beat_n] <= o_tdata;
            beat_last[beat_n] <= o_tlast;
            beat_cyc[beat_n]  <= cyc;
            beat_n            <= beat_n + 1;
        end
        if (o_len_err)
            len_err_n <= len_err_n + 1;
        if (o_fifo_rd_en && i_fifo_empty)
            bad_pop_n <= bad_pop_n + 1;
    end

    typedef struct {
        bit          tready;
        bit          rd_en;
        bit          tvalid;
        logic [31:0] tdata;
        bit          tlast;
        int          pkt;
        bit          busy;
    } vec_t;

    vec_t t1 [0:5];
    vec_t t3 [0:11];

    int checks = 0;
    int passes = 0;

    function automatic vec_t mkVec(bit tr, bit rd, bit tv, logic [31:0] d, bit l, int p, bit b);
        vec_t v;
        v.tready = tr;
        v.rd_en  = rd;
        v.tvalid = tv;
        v.tdata  = d;
        v.tlast  = l;
        v.pkt    = p;
        v.busy   = b;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input bit tready);
        i_tready = tready;
    endtask

    task automatic pushWord(input logic [31:0] w);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr                = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic runTable(input string tag, input vec_t row);
        applyStimulus(row.tready);
        @(negedge clk);
        checkOutput({tag, "_rd_en"},  64'(o_fifo_rd_en), 64'(row.rd_en));
        checkOutput({tag, "_tvalid"}, 64'(o_tvalid),     64'(row.tvalid));
        checkOutput({tag, "_busy"},   64'(o_busy),       64'(row.busy));
        checkOutput({tag, "_pkt"},    64'(o_pkt_cnt),    64'(row.pkt));
        if (row.tvalid) begin
            checkOutput({tag, "_tdata"}, 64'(o_tdata), 64'(row.tdata));
            checkOutput({tag, "_tlast"}, 64'(o_tlast), 64'(row.tlast));
        end
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int b0;
        int e0;
        bit done;

        // hdr=3 {A,B,C} with the stream always ready
        t1[0] = mkVec(1, 1, 0, 32'h0, 0, 0, 0);
        t1[1] = mkVec(1, 1, 0, 32'h0, 0, 0, 1);
        t1[2] = mkVec(1, 1, 1, 32'hA, 0, 0, 1);
        t1[3] = mkVec(1, 1, 1, 32'hB, 0, 0, 1);
        t1[4] = mkVec(1, 0, 1, 32'hC, 1, 0, 1);
        t1[5] = mkVec(1, 0, 0, 32'h0, 0, 1, 0);

        // hdr=4 {1,2,3,4} with the stream stalled until the skid buffer fills
        t3[0]  = mkVec(0, 1, 0, 32'h0, 0, 3, 0);
        t3[1]  = mkVec(0, 1, 0, 32'h0, 0, 3, 1);
        t3[2]  = mkVec(0, 1, 1, 32'h1, 0, 3, 1);
        t3[3]  = mkVec(0, 0, 1, 32'h1, 0, 3, 1);
        t3[4]  = mkVec(0, 0, 1, 32'h1, 0, 3, 1);
        t3[5]  = mkVec(0, 0, 1, 32'h1, 0, 3, 1);
        t3[6]  = mkVec(0, 0, 1, 32'h1, 0, 3, 1);
        t3[7]  = mkVec(1, 0, 1, 32'h1, 0, 3, 1);
        t3[8]  = mkVec(1, 1, 1, 32'h2, 0, 3, 1);
        t3[9]  = mkVec(1, 1, 1, 32'h3, 0, 3, 1);
        t3[10] = mkVec(1, 0, 1, 32'h4, 1, 3, 1);
        t3[11] = mkVec(1, 0, 0, 32'h0, 0, 4, 0);

        rst_n = 1'b0;
        i_clr = 1'b0;
        applyStimulus(1'b1);
        repeat (3) step();

        // Reset values
        @(negedge clk);
        checkOutput("rst_tvalid",  64'(o_tvalid),  64'd0);
        checkOutput("rst_tlast",   64'(o_tlast),   64'd0);
        checkOutput("rst_tdata",   64'(o_tdata),   64'd0);
        checkOutput("rst_pkt",     64'(o_pkt_cnt), 64'd0);
        checkOutput("rst_len_err", 64'(o_len_err), 64'd0);
        checkOutput("rst_busy",    64'(o_busy),    64'd0);
        step();

        // Basic three-beat packet
        pushWord(32'd3);
        pushWord(32'hA);
        pushWord(32'hB);
        pushWord(32'hC);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            runTable($sformatf("t1_c%0d", i), t1[i]);

        // Back-to-back packets with one header bubble
        b0 = beat_n;
        pushWord(32'd1);
        pushWord(32'h11);
        pushWord(32'd2);
        pushWord(32'h21);
        pushWord(32'h22);
        repeat (8) step();
        checkOutput("t2_beats", 64'(beat_n - b0), 64'd3);
        checkOutput("t2_d0",    64'(beat_data[b0]),     64'h11);
        checkOutput("t2_l0",    64'(beat_last[b0]),     64'd1);
        checkOutput("t2_d1",    64'(beat_data[b0 + 1]), 64'h21);
        checkOutput("t2_l1",    64'(beat_last[b0 + 1]), 64'd0);
        checkOutput("t2_d2",    64'(beat_data[b0 + 2]), 64'h22);
        checkOutput("t2_l2",    64'(beat_last[b0 + 2]), 64'd1);
        checkOutput("t2_gap01", 64'(beat_cyc[b0 + 1] - beat_cyc[b0]),     64'd2);
        checkOutput("t2_gap12", 64'(beat_cyc[b0 + 2] - beat_cyc[b0 + 1]), 64'd1);
        checkOutput("t2_pkt",   64'(o_pkt_cnt), 64'd3);

        // Back-pressure: skid buffer fills, pops stop, nothing lost or duplicated
        b0 = beat_n;
        pushWord(32'd4);
        pushWord(32'h1);
        pushWord(32'h2);
        pushWord(32'h3);
        pushWord(32'h4);
        for (int i = 0; i < 12; i++)
            runTable($sformatf("t3_c%0d", i), t3[i]);
        checkOutput("t3_beats", 64'(beat_n - b0), 64'd4);

        // Zero-length header followed by a one-beat packet
        b0 = beat_n;
        e0 = len_err_n;
        pushWord(32'd0);
        pushWord(32'd1);
        pushWord(32'h55);
        repeat (6) step();
        checkOutput("t4_len_err_pulses", 64'(len_err_n - e0), 64'd1);
        checkOutput("t4_beats", 64'(beat_n - b0), 64'd1);
        checkOutput("t4_data",  64'(beat_data[b0]), 64'h55);
        checkOutput("t4_last",  64'(beat_last[b0]), 64'd1);
        checkOutput("t4_pkt",   64'(o_pkt_cnt), 64'd5);

        // Flush after two accepted beats of a five-beat packet
        b0 = beat_n;
        pushWord(32'd5);
        for (int i = 1; i <= 5; i++)
            pushWord(32'h50 + 32'(i));
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            if (beat_n - b0 >= 2)
                done = 1'b1;
        end
        checkOutput("t5_two_beats_seen", 64'(done), 64'd1);
        checkOutput("t5_d0", 64'(beat_data[b0]),     64'h51);
        checkOutput("t5_d1", 64'(beat_data[b0 + 1]), 64'h52);
        checkOutput("t5_l1", 64'(beat_last[b0 + 1]), 64'd0);
        i_clr = 1'b1;
        @(negedge clk);
        checkOutput("t5_clr_rd_en", 64'(o_fifo_rd_en), 64'd0);
        step();
        i_clr = 1'b0;
        @(negedge clk);
        checkOutput("t5_post_tvalid", 64'(o_tvalid),  64'd0);
        checkOutput("t5_post_tlast",  64'(o_tlast),   64'd0);
        checkOutput("t5_post_busy",   64'(o_busy),    64'd0);
        checkOutput("t5_post_pkt",    64'(o_pkt_cnt), 64'd5);
        step();
        b0 = beat_n;
        pushWord(32'd1);
        pushWord(32'h77);
        repeat (5) step();
        checkOutput("t5_after_beats", 64'(beat_n - b0), 64'd1);
        checkOutput("t5_after_data",  64'(beat_data[b0]), 64'h77);
        checkOutput("t5_after_last",  64'(beat_last[b0]), 64'd1);
        checkOutput("t5_after_pkt",   64'(o_pkt_cnt), 64'd6);

        // Trickling upstream: one payload word every three cycles
        b0 = beat_n;
        pushWord(32'd3);
        repeat (3) step();
        pushWord(32'h31);
        repeat (3) step();
        pushWord(32'h32);
        repeat (3) step();
        pushWord(32'h33);
        repeat (3) step();
        checkOutput("t6_beats",    64'(beat_n - b0), 64'd3);
        checkOutput("t6_d0",       64'(beat_data[b0]),     64'h31);
        checkOutput("t6_d2",       64'(beat_data[b0 + 2]), 64'h33);
        checkOutput("t6_l1",       64'(beat_last[b0 + 1]), 64'd0);
        checkOutput("t6_l2",       64'(beat_last[b0 + 2]), 64'd1);
        checkOutput("t6_gap01",    64'(beat_cyc[b0 + 1] - beat_cyc[b0]),     64'd3);
        checkOutput("t6_gap12",    64'(beat_cyc[b0 + 2] - beat_cyc[b0 + 1]), 64'd3);
        checkOutput("t6_pkt",      64'(o_pkt_cnt), 64'd7);
        checkOutput("t6_bad_pops", 64'(bad_pop_n), 64'd0);

        // Reset in the middle of a packet
        pushWord(32'd3);
        pushWord(32'h61);
        repeat (3) step();
        pushWord(32'h62);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_rd_en", 64'(o_fifo_rd_en), 64'd0);
        step();
        @(negedge clk);
        checkOutput("t6_rst_tvalid",  64'(o_tvalid),  64'd0);
        checkOutput("t6_rst_tdata",   64'(o_tdata),   64'd0);
        checkOutput("t6_rst_tlast",   64'(o_tlast),   64'd0);
        checkOutput("t6_rst_pkt",     64'(o_pkt_cnt), 64'd0);
        checkOutput("t6_rst_len_err", 64'(o_len_err), 64'd0);
        checkOutput("t6_rst_busy",    64'(o_busy),    64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_rel_rd_en",  64'(o_fifo_rd_en), 64'd0);
        checkOutput("t6_rel_tvalid", 64'(o_tvalid),     64'd0);
        checkOutput("t6_rel_busy",   64'(o_busy),       64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fwft_fifo_pkt_reader.md
Name: fwft_fifo_pkt_reader

Overview:
- Consumer for the read side of the team's synchronous FWFT FIFOs. Pops length-prefixed packets and emits them on a valid/ready stream with an end-of-packet marker.
- The header word carries the payload beat count and is not forwarded.
- Sits between a packet FIFO and downstream stream logic (DMA, serializer).
- An internal 2-entry skid buffer keeps i_tready out of the FIFO pop path while sustaining one beat per cycle.

Parameters:
DATA_WIDTH, 32, width of FIFO words and stream data
LEN_WIDTH, 16, header length field width, taken from header bits [LEN_WIDTH-1:0]; must be <= DATA_WIDTH
CNT_WIDTH, 16, width of completed-packet counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active-low
i_clr  input  1  synchronous flush, normally shared with the FIFO clear
i_fifo_empty  input  1  FIFO empty; when 0, i_fifo_rd_data is valid in the same cycle (FWFT)
i_fifo_rd_data  input  DATA_WIDTH  FIFO head word
o_fifo_rd_en  output  1  pop; the head word is consumed at this clock edge
o_tvalid  output  1  stream beat valid
o_tdata  output  DATA_WIDTH  stream data
o_tlast  output  1  last beat of packet
i_tready  input  1  downstream accepts beat
o_pkt_cnt  output  CNT_WIDTH  packets completed (tlast beats accepted); wraps
o_len_err  output  1  one-cycle pulse when a zero-length header is popped
o_busy  output  1  state != IDLE or skid buffer non-empty

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, remaining-count 0, buffer empty.
  - Registered outputs after reset: o_tvalid=0, o_tlast=0, o_tdata=0, o_pkt_cnt=0, o_len_err=0.
  - o_fifo_rd_en is forced 0 while rst_n=0.
- FSM states: IDLE (expecting header) and PAYLOAD.
- IDLE:
  - o_fifo_rd_en = !i_fifo_empty. The header pop needs no buffer space.
  - len = header[LEN_WIDTH-1:0].
  - len=0: o_len_err=1 in the next cycle; stay IDLE.
  - Otherwise: remaining <= len; go to PAYLOAD.
- PAYLOAD:
  - o_fifo_rd_en = !i_fifo_empty && (buf_count < 2). It does not depend on i_tready.
  - Each pop writes {data, last = (remaining==1)} into the buffer and decrements remaining.
  - When remaining==1 is popped, go to IDLE. The next header may be popped in the following cycle while the buffer still drains.
- Latency: header popped at edge N, first payload popped at edge N+1. o_tvalid=1 in the cycle after N+1. Steady state is 1 beat/cycle with a one-cycle header bubble per packet.
- Skid buffer:
  - 2 entries, FIFO order. The output register holds the head entry.
  - o_tvalid = (buf_count != 0).
  - A beat transfers when o_tvalid && i_tready.
  - o_tdata and o_tlast must stay stable while o_tvalid=1 and i_tready=0.
  - Simultaneous push and pop leaves count unchanged, and data order is preserved.
  - A push when count==2 cannot occur (guarded by the pop condition).
- o_pkt_cnt increments on each accepted beat with o_tlast=1, modulo 2^CNT_WIDTH.
- i_clr (synchronous, priority below rst_n):
  - In the clr cycle, o_fifo_rd_en is forced 0.
  - Next cycle: state IDLE, remaining 0, buffer empty, o_tvalid=0, o_tlast=0.
  - o_pkt_cnt is retained.
  - A packet in flight is truncated with no tlast. Downstream must treat clr as an abort.
- Upstream empty mid-packet: no pop, the FSM holds in PAYLOAD, o_tvalid drops once the buffer drains. There is no timeout.
- Length arithmetic: remaining is LEN_WIDTH bits, and the maximum packet is 2^LEN_WIDTH-1 beats. Header bits above LEN_WIDTH are ignored.

Test Plan:
1. FIFO preloaded {hdr=3, 0xA, 0xB, 0xC}, i_tready=1 -> o_fifo_rd_en high for 4 consecutive cycles; o_tvalid for 3 cycles with data 0xA, 0xB, 0xC; o_tlast only with 0xC; o_pkt_cnt 0->1; o_busy low afterwards.
2. Back-to-back {hdr=1, 0x11, hdr=2, 0x21, 0x22} -> beats 0x11(last), 0x21, 0x22(last); exactly one bubble cycle between packets; o_pkt_cnt=2.
3. hdr=4 (0x1..0x4), i_tready=0 for 5 cycles from the first payload pop -> exactly 2 payload pops, then o_fifo_rd_en=0; o_tdata holds 0x1; after i_tready=1, beats 0x1..0x4 in order, none lost or duplicated.
4. {hdr=0, hdr=1, 0x55} -> o_len_err pulses exactly one cycle; no beat for the zero-length header; then 0x55 with tlast; o_pkt_cnt=1.
5. hdr=5, i_clr asserted after 2 beats accepted -> o_fifo_rd_en=0 in the clr cycle; o_tvalid=0 next cycle; state IDLE; o_pkt_cnt unchanged; a subsequent {hdr=1, 0x77} is emitted correctly with tlast.
6. hdr=3 with payload words written one every 3 cycles (i_fifo_empty toggling); then rst_n=0 mid-packet -> pops only when !empty; tvalid bubbles; tlast on the 3rd beat. After reset, all outputs match reset values and o_pkt_cnt=0.
